phase_accumulator: RTL

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

---
 rtl/dds_pkg.sv | 10 +
 rtl/tick_divider.sv | 17 +
 rtl/phase_accumulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared state type and default parameters for the DDS phase accumulator.
package dds_pkg;
  localparam int DEFAULT_PHASE_WIDTH = 32;
  localparam int DEFAULT_TICK_DIV = 1;
`ifdef PHASE_ACC_SWEEP_EN
  typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every TICK_DIV cycles while run is high; counter held at 0 otherwise.
module tick_divider
  import dds_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);
  logic [15:0] cnt;
  logic last;
  assign last = cnt == 16'(TICK_DIV - 1);
  assign tick = run && last;
  always_ff @(posedge clk) cnt <= (reset || !run || last) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/phase_accumulator.sv
// phase_accumulator: DDS phase accumulator with tick divider and optional FTW sweep.
// Define PHASE_ACC_SWEEP_EN to build the SWEEP state; otherwise sweep inputs are ignored.
module phase_accumulator
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_load,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic                   acc_clr,
  input  logic                   sweep_start,
  input  logic [PHASE_WIDTH-1:0] sweep_step,
  input  logic [PHASE_WIDTH-1:0] ftw_stop,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   sample_en,
  output logic                   wrap,
  output logic                   sweep_done
);
  localparam int W = PHASE_WIDTH;
  state_t state, state_nx;
  logic [W-1:0] acc, ftw_reg, ftw_nx;
  logic [W:0] sum;
  logic active, tick;
  assign active = run && state != IDLE;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .run(active), .tick(tick));
  assign sum = {1'b0, acc} + {1'b0, ftw_reg};
`ifdef PHASE_ACC_SWEEP_EN
  logic [W:0] swp_sum;
  logic [W-1:0] swp_ftw;
  logic done_nx;
  assign swp_sum = {1'b0, ftw_reg} + {1'b0, sweep_step};
  assign swp_ftw = swp_sum >= {1'b0, ftw_stop} ? ftw_stop : swp_sum[W-1:0];
  always_comb begin
    state_nx = state;
    ftw_nx = ftw_reg;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        ftw_nx = ftw_load ? ftw_in : ftw_reg;
        state_nx = run ? RUN : IDLE;
      end
      RUN: begin
        ftw_nx = ftw_load ? ftw_in : ftw_reg;
        if (!run) state_nx = IDLE;
        else if (sweep_start && ftw_reg >= ftw_stop) done_nx = 1'b1;
        else if (sweep_start) state_nx = SWEEP;
      end
      SWEEP: begin
        if (!run) state_nx = IDLE;
        else if (tick) begin
          ftw_nx = swp_ftw;
          done_nx = swp_ftw == ftw_stop;
          state_nx = swp_ftw == ftw_stop ? RUN : SWEEP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) sweep_done <= reset ? 1'b0 : done_nx;
`else
  always_comb begin
    state_nx = run ? RUN : IDLE;
    ftw_nx = ftw_load ? ftw_in : ftw_reg;
  end
  assign sweep_done = &{1'b0, sweep_start, ^sweep_step, ^ftw_stop};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ftw_reg <= '0;
    end else begin
      state <= state_nx;
      ftw_reg <= ftw_nx;
    end
  end
  // acc_clr wins over a coincident tick and suppresses that sample
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      phase <= '0;
      sample_en <= 1'b0;
      wrap <= 1'b0;
    end else if (acc_clr) begin
      acc <= '0;
      phase <= phase_offset;
      sample_en <= 1'b0;
      wrap <= 1'b0;
    end else if (tick) begin
      acc <= sum[W-1:0];
      phase <= sum[W-1:0] + phase_offset;
      sample_en <= 1'b1;
      wrap <= sum[W];
    end else begin
      sample_en <= 1'b0;
      wrap <= 1'b0;
    end
  end
endmodule
